// File: rtl/system_reset_sequencer_if.sv
// Reset sequencer signal bundle: the debug-module soft request going in and
// the ordered reset outputs going out to the core complex.
interface system_reset_sequencer_if;
    logic sw_reset_req;
    logic uncore_reset;
    logic core_reset;
    logic reset_done;
    logic sw_reset_ack;

    modport master (
        input  sw_reset_req,
        output uncore_reset,
        output core_reset,
        output reset_done,
        output sw_reset_ack
    );

    modport slave (
        output sw_reset_req,
        input  uncore_reset,
        input  core_reset,
        input  reset_done,
        input  sw_reset_ack
    );
endinterface

// File: rtl/system_reset_sequencer.sv
// System reset sequencer: synchronizes raw reset release, holds the uncore
// in reset for HOLD_CYCLES, then releases the core CORE_DELAY cycles later.
// Debug-module soft requests re-reset only the core and acknowledge on finish.
module system_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int CORE_DELAY  = 8,
    parameter int CNT_W       = 8
) (
    input logic clock,
    input logic reset_n,
    system_reset_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_UNCORE_REL,
        ST_RUN,
        ST_SOFT
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LOAD = CNT_W'(CORE_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   rst_sync;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   soft_pend;
    logic                   req_q;
    logic                   req_edge;
    logic                   uncore_reset_q;
    logic                   core_reset_q;
    logic                   reset_done_q;
    logic                   sw_reset_ack_q;

    // Assertion is immediate, release ripples a 1 through the stages so the
    // sequencer only ever sees a clock-aligned deassertion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync[SYNC_STAGES-1];
    assign req_edge = bus.sw_reset_req & ~req_q;

    // Sequencing FSM with one shared down-counter; outputs are registered
    // alongside each state change so nothing reaches the pins combinationally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_ASSERT;
            cnt            <= HOLD_LOAD;
            soft_pend      <= 1'b0;
            req_q          <= 1'b1;
            uncore_reset_q <= 1'b1;
            core_reset_q   <= 1'b1;
            reset_done_q   <= 1'b0;
            sw_reset_ack_q <= 1'b0;
        end else begin
            req_q          <= bus.sw_reset_req;
            sw_reset_ack_q <= 1'b0;
            case (state)
                ST_ASSERT: begin
                    if (!rst_sync) begin
                        cnt <= HOLD_LOAD;
                    end else if (cnt == '0) begin
                        state          <= ST_UNCORE_REL;
                        cnt            <= CORE_LOAD;
                        uncore_reset_q <= 1'b0;
                        core_reset_q   <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_UNCORE_REL: begin
                    if (cnt == '0) begin
                        state          <= ST_RUN;
                        uncore_reset_q <= 1'b0;
                        core_reset_q   <= 1'b0;
                        reset_done_q   <= 1'b1;
                        sw_reset_ack_q <= soft_pend;
                        soft_pend      <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (req_edge) begin
                        state        <= ST_SOFT;
                        cnt          <= HOLD_LOAD;
                        core_reset_q <= 1'b1;
                        reset_done_q <= 1'b0;
                    end
                end
                ST_SOFT: begin
                    if (cnt == '0) begin
                        state     <= ST_UNCORE_REL;
                        cnt       <= CORE_LOAD;
                        soft_pend <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state          <= ST_ASSERT;
                    cnt            <= HOLD_LOAD;
                    uncore_reset_q <= 1'b1;
                    core_reset_q   <= 1'b1;
                    reset_done_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.uncore_reset = uncore_reset_q;
    assign bus.core_reset   = core_reset_q;
    assign bus.reset_done   = reset_done_q;
    assign bus.sw_reset_ack = sw_reset_ack_q;

endmodule

// File: tb/tb_system_reset_sequencer.sv
// Scoreboard bench for system_reset_sequencer: stimulus pushes the expected
// output transitions (edge number after reset release, output vector) and
// per-DUT monitors pop and compare whenever the outputs change.
module tb_system_reset_sequencer;

    typedef struct {
        int         edge_n;
        logic [3:0] vec;
    } exp_t;

    logic clock;
    logic reset_n;
    int   edge_cnt;
    int   n_vec;
    int   n_err;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [3:0] vec_a;
    logic [3:0] vec_b;

    system_reset_sequencer_if bus_a ();
    system_reset_sequencer_if bus_b ();

    system_reset_sequencer #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16),
        .CORE_DELAY (8),
        .CNT_W      (8)
    ) dut_a (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_a)
    );

    system_reset_sequencer #(
        .SYNC_STAGES(3),
        .HOLD_CYCLES(1),
        .CORE_DELAY (1),
        .CNT_W      (8)
    ) dut_b (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus_b)
    );

    // Vector order: {uncore_reset, core_reset, reset_done, sw_reset_ack}
    assign vec_a = {bus_a.uncore_reset, bus_a.core_reset, bus_a.reset_done, bus_a.sw_reset_ack};
    assign vec_b = {bus_b.uncore_reset, bus_b.core_reset, bus_b.reset_done, bus_b.sw_reset_ack};

    // Free-running clock, 10 time units per cycle
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Edge index since reset release: the first rising edge after release is 1
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    task automatic checkOutput(input string name, input int act_edge, input logic [3:0] act_vec,
                               input int exp_edge, input logic [3:0] exp_vec);
        n_vec++;
        if (act_edge != exp_edge || act_vec !== exp_vec) begin
            n_err++;
            $display("[TB] FAIL %s: got edge %0d vec %b, expected edge %0d vec %b",
                     name, act_edge, act_vec, exp_edge, exp_vec);
        end
    endtask

    task automatic pop_a();
        exp_t e;
        if (q_a.size() == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL dut_a unexpected change: got edge %0d vec %b, expected no change",
                     edge_cnt, vec_a);
        end else begin
            e = q_a.pop_front();
            checkOutput("dut_a", edge_cnt, vec_a, e.edge_n, e.vec);
        end
    endtask

    task automatic pop_b();
        exp_t e;
        if (q_b.size() == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL dut_b unexpected change: got edge %0d vec %b, expected no change",
                     edge_cnt, vec_b);
        end else begin
            e = q_b.pop_front();
            checkOutput("dut_b", edge_cnt, vec_b, e.edge_n, e.vec);
        end
    endtask

    // Monitor for the default-parameter instance
    initial begin
        #2;
        pop_a();
        forever begin
            @(vec_a);
            #1;
            pop_a();
        end
    end

    // Monitor for the corner-parameter instance
    initial begin
        #2;
        pop_b();
        forever begin
            @(vec_b);
            #1;
            pop_b();
        end
    end

    task automatic push_a(input int e, input logic [3:0] v);
        exp_t x;
        x.edge_n = e;
        x.vec    = v;
        q_a.push_back(x);
    endtask

    task automatic push_b(input int e, input logic [3:0] v);
        exp_t x;
        x.edge_n = e;
        x.vec    = v;
        q_b.push_back(x);
    endtask

    // Power-on style release timing for both instances
    task automatic push_release();
        push_a(18, 4'b0100);
        push_a(26, 4'b0010);
        push_b(4, 4'b0100);
        push_b(5, 4'b0010);
    endtask

    // Park on the falling clock that follows edge n (bounded wait)
    task automatic wait_to_edge(input int n);
        int guard;
        guard = 0;
        while (edge_cnt != n && guard < 500) begin
            @(negedge clock);
            guard++;
        end
        if (edge_cnt != n) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL wait_to_edge: got edge %0d, expected edge %0d", edge_cnt, n);
        end
    endtask

    task automatic applyStimulus(input logic rst_val, input logic req_a_val, input logic req_b_val);
        reset_n            = rst_val;
        bus_a.sw_reset_req = req_a_val;
        bus_b.sw_reset_req = req_b_val;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        push_a(0, 4'b1100);
        push_b(0, 4'b1100);
        push_release();
        #1 applyStimulus(1'b0, 1'b0, 1'b0);
        #2 applyStimulus(1'b1, 1'b0, 1'b0);

        // Corner instance soft reset sampled at edge 60
        push_b(60, 4'b0100);
        push_b(62, 4'b0011);
        push_b(63, 4'b0010);
        // Default instance soft reset sampled at edge 40, then held high
        push_a(40, 4'b0100);
        push_a(64, 4'b0011);
        push_a(65, 4'b0010);
        wait_to_edge(39);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to_edge(59);
        applyStimulus(1'b1, 1'b1, 1'b1);
        wait_to_edge(70);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to_edge(144);
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Fresh request at 150 with a second pulse inside SOFT that must be ignored
        push_a(150, 4'b0100);
        push_a(174, 4'b0011);
        push_a(175, 4'b0010);
        wait_to_edge(149);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to_edge(154);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_to_edge(159);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to_edge(180);
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Soft reset at 190, then a short reset_n glitch during UNCORE_REL
        push_a(190, 4'b0100);
        wait_to_edge(189);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to_edge(210);
        push_a(0, 4'b1100);
        push_b(0, 4'b1100);
        push_release();
        #1 applyStimulus(1'b0, 1'b1, 1'b0);
        #3 applyStimulus(1'b1, 1'b1, 1'b0);

        // Second epoch: request at 40, reset_n asserted mid-SOFT
        push_a(40, 4'b0100);
        wait_to_edge(30);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_to_edge(39);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to_edge(45);
        push_a(0, 4'b1100);
        push_b(0, 4'b1100);
        push_release();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        // Request still high at release: no soft sequence may follow
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_to_edge(90);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_to_edge(100);

        n_vec++;
        if (q_a.size() != 0) begin
            n_err++;
            $display("[TB] FAIL dut_a pending: %0d expected events never seen, expected 0", q_a.size());
        end
        n_vec++;
        if (q_b.size() != 0) begin
            n_err++;
            $display("[TB] FAIL dut_b pending: %0d expected events never seen, expected 0", q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/system_reset_sequencer.md
# system_reset_sequencer

Consumes the raw system reset produced by the bench/board reset source and turns it into the ordered, clock-synchronous resets the core complex needs. Synchronizes reset deassertion, holds the uncore in reset for a programmable time, releases the core after a further delay, and services debug-module soft ("ndreset") requests that re-reset only the core. Sits directly between the system reset source and the core's `reset` inputs.

## Interface
- `SYNC_STAGES`, 2, deassertion synchronizer depth (>=2)
- `HOLD_CYCLES`, 16, cycles uncore stays in reset after synchronized release (1..2^CNT_W)
- `CORE_DELAY`, 8, cycles between uncore release and core release (1..2^CNT_W)
- `CNT_W`, 8, sequence counter width
- `clock`  in  1  sole clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset; assertion asynchronous, deassertion synchronized internally
- `sw_reset_req`  in  1  soft core-reset request from debug module; rising edge significant
- `uncore_reset`  out  1  active-high reset to uncore/interconnect
- `core_reset`  out  1  active-high reset to hart(s)
- `reset_done`  out  1  high while all resets released
- `sw_reset_ack`  out  1  one-cycle pulse: soft reset sequence complete

## Operation
- Synchronizer: `SYNC_STAGES` flops, async-cleared by `reset_n`, shifting in 1; last stage = `rst_sync`.
- Single down-counter `cnt[CNT_W-1:0]`; FSM states: ASSERT, UNCORE_REL, RUN, SOFT.
- ASSERT: `uncore_reset`=1, `core_reset`=1. While `rst_sync`=0, `cnt` loads `HOLD_CYCLES-1`. While `rst_sync`=1: if `cnt`==0 -> UNCORE_REL, load `CORE_DELAY-1`; else decrement.
- UNCORE_REL: `uncore_reset`=0, `core_reset`=1. `cnt`==0 -> RUN; else decrement.
- RUN: both resets 0, `reset_done`=1. Rising edge of `sw_reset_req` (req high, previous-cycle req low) -> SOFT, load `HOLD_CYCLES-1`.
- SOFT: `uncore_reset`=0, `core_reset`=1, `reset_done`=0. `cnt`==0 -> UNCORE_REL with load `CORE_DELAY-1` and internal `soft_pend`=1; else decrement.
- `sw_reset_ack` pulses for the one cycle after entry into RUN when `soft_pend`=1; `soft_pend` clears on that entry.
- `sw_reset_req` rising edges outside RUN are dropped: no ack, no queueing. Level held high does not retrigger; low then high again is required.
- All outputs driven from flops (state-decoded registers), no combinational paths from inputs.
- `reset_n` low at any time, including mid-SOFT or mid-UNCORE_REL: asynchronously `uncore_reset`=1, `core_reset`=1, `reset_done`=0, `sw_reset_ack`=0, state ASSERT, `soft_pend`=0, synchronizer cleared, req edge-detector flop cleared to 1 (a req already high at release is not an edge).

## Timing
- Reset values: `uncore_reset`=1, `core_reset`=1, `reset_done`=0, `sw_reset_ack`=0.
- Edge 1 = first rising `clock` after `reset_n` rises (setup met). `rst_sync`=1 after edge S=`SYNC_STAGES`.
- `uncore_reset` falls after edge S+`HOLD_CYCLES`; `core_reset` falls and `reset_done` rises after edge S+`HOLD_CYCLES`+`CORE_DELAY`. Defaults: edges 18 and 26.
- Soft: req rising edge sampled at edge N -> `core_reset`=1, `reset_done`=0 after N; `core_reset` falls, `reset_done` rises after edge N+`HOLD_CYCLES`+`CORE_DELAY`; `sw_reset_ack` high for the cycle following that same edge. `uncore_reset` stays 0 throughout.
- `reset_n` glitch shorter than a clock period still fully restarts the sequence.

## Test plan
- Power-on, defaults: `reset_n` released before edge 1 -> `uncore_reset` low after edge 18, `core_reset` low/`reset_done` high after edge 26; `sw_reset_ack` never pulses.
- Soft reset: in RUN, `sw_reset_req` 0->1 sampled at edge 40 -> `core_reset` high edges 40..64, low after 64; `uncore_reset` stays 0; `sw_reset_ack` single pulse after edge 64.
- Held/duplicate request: `sw_reset_req` held high 100 cycles -> exactly one soft sequence, one ack; second pulse issued during SOFT -> ignored, no second sequence.
- Mid-sequence reset: assert `reset_n` during UNCORE_REL and again during SOFT -> all outputs at reset values immediately (same timestep, no clock), full power-on timing repeats from release, no stale ack.
- Parameter corner: `HOLD_CYCLES`=1, `CORE_DELAY`=1, `SYNC_STAGES`=3 -> `uncore_reset` low after edge 4, `core_reset` low after edge 5.
- Request at release: `sw_reset_req` already high when `reset_n` rises -> no soft sequence, no ack after reaching RUN.
